// File: rtl/tmds_encoder_if.sv
// Pixel-side bundle of one TMDS channel: pixel/control inputs in, 10-bit character out.
// The encoder is the slave; the upstream video pipeline is the master.
interface tmds_encoder_if;
    logic       de_i;
    logic [7:0] data_i;
    logic       c0_i;
    logic       c1_i;
    logic [9:0] tmds_o;

    modport master (output de_i, output data_i, output c0_i, output c1_i, input tmds_o);
    modport slave  (input de_i, input data_i, input c0_i, input c1_i, output tmds_o);
endinterface

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder: stage 1 does transition minimisation (q_m);
// stage 2 does DC balancing with a running disparity, or inserts control tokens.
module tmds_encoder (
    input  logic          clk,
    input  logic          rst,
    tmds_encoder_if.slave bus
);

    localparam logic [9:0] TOKEN_00 = 10'h354;
    localparam logic [9:0] TOKEN_01 = 10'h0AB;
    localparam logic [9:0] TOKEN_10 = 10'h154;
    localparam logic [9:0] TOKEN_11 = 10'h2AB;

    // Stage 1 state
    logic [8:0] qm_d, qm_q;
    logic       de_d, de_q;
    logic       c0_d, c0_q;
    logic       c1_d, c1_q;
    logic       vld_d, vld_q;

    // Stage 2 state
    logic [9:0]        tmds_d, tmds_q;
    logic signed [4:0] cnt_d, cnt_q;

    logic [3:0]        n1d;
    logic              use_xnor;
    logic [3:0]        n1q;
    logic [3:0]        n0q;
    logic signed [4:0] diff;

    // Stage 1: choose XOR/XNOR chaining to minimise transitions.
    always_comb begin
        n1d = '0;
        for (int i = 0; i < 8; i++) begin
            n1d = n1d + 4'(bus.data_i[i]);
        end
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !bus.data_i[0]);

        qm_d[0] = bus.data_i[0];
        for (int i = 1; i < 8; i++) begin
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ bus.data_i[i]) : (qm_d[i-1] ^ bus.data_i[i]);
        end
        qm_d[8] = ~use_xnor;

        de_d  = bus.de_i;
        c0_d  = bus.c0_i;
        c1_d  = bus.c1_i;
        vld_d = 1'b1;
    end

    // Stage 2: diff is n1q - n0q of the registered q_m, always even in [-8, 8].
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        tmds_d = '0;
        cnt_d  = '0;

        n1q = '0;
        for (int i = 0; i < 8; i++) begin
            n1q = n1q + 4'(qm_q[i]);
        end
        n0q  = 4'd8 - n1q;
        diff = $signed(5'(n1q)) - $signed(5'(n0q));

        if (!vld_q) begin
            // Stage 1 still holds reset contents: keep the line at zero.
            tmds_d = '0;
            cnt_d  = '0;
        end else if (!de_q) begin
            cnt_d = '0;
            unique case ({c1_q, c0_q})
                2'b00:   tmds_d = TOKEN_00;
                2'b01:   tmds_d = TOKEN_01;
                2'b10:   tmds_d = TOKEN_10;
                default: tmds_d = TOKEN_11;
            endcase
        end else if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
            tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
            cnt_d  = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                     ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
            tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
            cnt_d  = cnt_q - diff + (qm_q[8] ? 5'sd2 : 5'sd0);
        end else begin
            tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
            cnt_d  = cnt_q + diff - (qm_q[8] ? 5'sd0 : 5'sd2);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            qm_q   <= '0;
            de_q   <= 1'b0;
            c0_q   <= 1'b0;
            c1_q   <= 1'b0;
            vld_q  <= 1'b0;
            tmds_q <= '0;
            cnt_q  <= '0;
        end else begin
            qm_q   <= qm_d;
            de_q   <= de_d;
            c0_q   <= c0_d;
            c1_q   <= c1_d;
            vld_q  <= vld_d;
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.tmds_o = tmds_q;

endmodule
